instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Program-counter and fetch sequencer that drives the address side of the 1024-word synchronous instruction memory and delivers a qualified instruction stream to decode. It selects one of the resident programs (fibonacci, factorial, synthetic) or an arbitrary start address. It then fetches sequentially, absorbs decode stalls without losing the word in flight, squashes on jump/branch redirects and stops on halt. It sits between the control/user-select logic and the decode stage, as the initiator for the memory's one-cycle registered read.

## Interface
- ADDR_W, 10, instruction address width (memory word index)
- DATA_W, 32, instruction width
- PROG1_BASE, 0, fibonacci entry address
- PROG2_BASE, 15, factorial entry address
- PROG3_BASE, 22, synthetic entry address
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces reset state immediately
- start  in  1  one-cycle pulse; begin fetching at the selected entry address
- prog_sel  in  2  0→PROG1_BASE, 1→PROG2_BASE, 2→PROG3_BASE, 3→start_addr
- start_addr  in  ADDR_W  entry address when prog_sel==3
- stall  in  1  decode cannot accept; hold the current instruction
- redirect_valid  in  1  jump/branch taken; refetch from redirect_addr
- redirect_addr  in  ADDR_W  redirect target
- halt_req  in  1  stop fetching
- mem_address  out  ADDR_W  address to instruction memory, combinational
- mem_instrucao  in  DATA_W  memory read data; valid the cycle after its address was presented
- instr_out  out  DATA_W  instruction to decode; mem_instrucao when instr_valid, else 0
- instr_pc  out  ADDR_W  address of instr_out
- instr_valid  out  1  instr_out/instr_pc are meaningful
- busy  out  1  state is FETCH

## Operation
- States: IDLE, FETCH, HALT.
- Registers: pc (next address to issue), inflight_pc, inflight_valid.
- IDLE/HALT: start → FETCH, pc←entry, inflight_valid←0. All other inputs are ignored.
- FETCH event priority, one action per edge:
  - start: restart at entry, inflight_valid←0.
  - halt_req: state→HALT, inflight_valid←0.
  - redirect_valid: pc←redirect_addr, inflight_valid←0. The word issued this cycle is squashed.
  - stall with inflight_valid=1: hold pc, inflight_pc and inflight_valid.
  - Otherwise: inflight_pc←pc, inflight_valid←1, pc←pc+1.
- pc+1 wraps modulo 2^ADDR_W (1023→0). There is no end-of-memory detection.
- mem_address = inflight_pc when (state==FETCH && stall && inflight_valid), else pc. Re-presenting inflight_pc keeps the registered memory output stable across a stall.
- Stall with inflight_valid=0 has no effect; fetch proceeds normally.
- instr_valid = (state==FETCH) && inflight_valid. instr_pc = inflight_pc.
- Decode consumes an instruction on any cycle where instr_valid=1 and stall=0.

## Timing
- Reset values: state IDLE, pc 0, inflight_pc 0, inflight_valid 0. Outputs: mem_address 0, instr_out 0, instr_pc 0, instr_valid 0, busy 0.
- Start latency: start at cycle t → mem_address=entry in t+1 → instr_valid=1 with the entry word in t+2.
- Steady state: one instruction per cycle, instr_pc incrementing by 1.
- Redirect penalty: redirect at t → mem_address=target in t+1 → instr_valid=0 in t+1 → target word valid in t+2. Exactly one bubble.
- Stall: instr_out, instr_pc and instr_valid stay constant on every stalled cycle. The cycle after stall drops delivers inflight_pc+1 with no bubble.
- Redirect and stall in the same cycle: redirect wins.
- halt_req and redirect in the same cycle: halt wins.
- start and halt_req in the same cycle: start wins.
- halt_req at t: instr_valid=0 from t+1. mem_address freezes at the last pc.
- Reset mid-fetch: all outputs return to reset values immediately, without waiting for a clock edge. The first edge after reset deasserts is still in IDLE.

## Test plan
- Reset, then start with prog_sel=1 → mem_address=15 next cycle; instr_valid=1 two cycles after start with instr_pc 15,16,17,… on consecutive cycles.
- Start with prog_sel=0 and hold stall high 3 cycles while instr_pc=3 → instr_pc stays 3 and mem_address stays 3; instr_pc=4 on the first cycle after stall drops.
- While instr_pc=9, assert redirect_valid with redirect_addr=5 → exactly one instr_valid=0 cycle, then instr_pc=5 followed by 6.
- Start with prog_sel=3, start_addr=1022 → instr_pc sequence 1022, 1023, 0, 1.
- Assert redirect_valid and halt_req together during FETCH → HALT, instr_valid=0, busy=0; a later start with prog_sel=2 → fetch resumes at 22.
- Assert reset asynchronously mid-stream with instr_valid=1 → instr_valid, busy and mem_address go to 0 before the next clock edge; no instruction is delivered until a new start.

Source files
------------

// File: rtl/instruction_fetch.sv
// Program-counter and fetch sequencer for a 1-cycle registered instruction memory.
// Selects a resident program entry, fetches sequentially, holds on stall, squashes on redirect.
module instruction_fetch #(
    parameter int                ADDR_W     = 10,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] PROG1_BASE = ADDR_W'(0),
    parameter logic [ADDR_W-1:0] PROG2_BASE = ADDR_W'(15),
    parameter logic [ADDR_W-1:0] PROG3_BASE = ADDR_W'(22)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        prog_sel,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_instrucao,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HALT
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] inflight_pc, inflight_pc_n;
    logic              inflight_valid, inflight_valid_n;
    logic [ADDR_W-1:0] entry;
    logic              hold;

    always_comb begin
        unique case (prog_sel)
            2'd0:    entry = PROG1_BASE;
            2'd1:    entry = PROG2_BASE;
            2'd2:    entry = PROG3_BASE;
            default: entry = start_addr;
        endcase
    end

    // While decode stalls, re-present the in-flight address so the memory output stays put.
    assign hold = (state == S_FETCH) && stall && inflight_valid;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n          = state;
        pc_n             = pc;
        inflight_pc_n    = inflight_pc;
        inflight_valid_n = inflight_valid;
        unique case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_n          = S_FETCH;
                    pc_n             = entry;
                    inflight_valid_n = 1'b0;
                end
            end
            S_FETCH: begin
                if (start) begin
                    pc_n             = entry;
                    inflight_valid_n = 1'b0;
                end else if (halt_req) begin
                    state_n          = S_HALT;
                    inflight_valid_n = 1'b0;
                end else if (redirect_valid) begin
                    pc_n             = redirect_addr;
                    inflight_valid_n = 1'b0;
                end else if (!hold) begin
                    inflight_pc_n    = pc;
                    inflight_valid_n = 1'b1;
                    pc_n             = pc + ADDR_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
        if (reset) begin
            state          <= S_IDLE;
            pc             <= '0;
            inflight_pc    <= '0;
            inflight_valid <= 1'b0;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            inflight_pc    <= inflight_pc_n;
            inflight_valid <= inflight_valid_n;
        end
    end

    assign mem_address = hold ? inflight_pc : pc;
    assign instr_valid = (state == S_FETCH) && inflight_valid;
    assign instr_pc    = inflight_pc;
    assign instr_out   = instr_valid ? mem_instrucao : '0;
    assign busy        = (state == S_FETCH);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a one-cycle registered memory model.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  prog_sel;
    logic [9:0]  start_addr;
    logic        stall;
    logic        redirect_valid;
    logic [9:0]  redirect_addr;
    logic        halt_req;
    logic [9:0]  mem_address;
    logic [31:0] mem_instrucao;
    logic [31:0] instr_out;
    logic [9:0]  instr_pc;
    logic        instr_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    instruction_fetch dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .prog_sel       (prog_sel),
        .start_addr     (start_addr),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .halt_req       (halt_req),
        .mem_address    (mem_address),
        .mem_instrucao  (mem_instrucao),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Memory contents are a recognisable function of the word address.
    function automatic logic [31:0] word(input logic [9:0] a);
        return 32'hC0DE_0000 | {22'd0, a};
    endfunction

    always_ff @(posedge clock) mem_instrucao <= word(mem_address);

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_instr(input string tag, input logic [9:0] pc);
        check({tag, " valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, " pc"}, {22'd0, instr_pc}, {22'd0, pc});
        check({tag, " word"}, instr_out, word(pc));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; prog_sel = 2'd0; start_addr = '0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_addr = '0; halt_req = 1'b0;
        #1;
        check("rst mem_address", {22'd0, mem_address}, 32'd0);
        check("rst instr_out", instr_out, 32'd0);
        check("rst instr_pc", {22'd0, instr_pc}, 32'd0);
        check("rst instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();
        check("idle after reset busy", {31'd0, busy}, 32'd0);

        // Start at factorial entry.
        start = 1'b1; prog_sel = 2'd1;
        tick();
        start = 1'b0;
        check("p2 mem_address", {22'd0, mem_address}, 32'd15);
        check("p2 busy", {31'd0, busy}, 32'd1);
        check("p2 bubble", {31'd0, instr_valid}, 32'd0);
        tick(); check_instr("p2 15", 10'd15);
        tick(); check_instr("p2 16", 10'd16);
        tick(); check_instr("p2 17", 10'd17);

        // Restart at fibonacci entry and stall on address 3.
        start = 1'b1; prog_sel = 2'd0;
        tick();
        start = 1'b0;
        check("p1 mem_address", {22'd0, mem_address}, 32'd0);
        check("p1 bubble", {31'd0, instr_valid}, 32'd0);
        tick(); check_instr("p1 0", 10'd0);
        tick(); check_instr("p1 1", 10'd1);
        tick(); check_instr("p1 2", 10'd2);
        tick(); check_instr("p1 3", 10'd3);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_instr("stall", 10'd3);
            check("stall mem_address", {22'd0, mem_address}, 32'd3);
            tick();
        end
        stall = 1'b0;
        #1;
        check_instr("stall release", 10'd3);
        check("stall release mem_address", {22'd0, mem_address}, 32'd4);
        tick(); check_instr("after stall", 10'd4);

        // Advance to 9, then redirect to 5.
        for (int a = 5; a <= 9; a++) begin
            tick();
            check_instr("seq", 10'(a));
        end
        redirect_valid = 1'b1; redirect_addr = 10'd5; stall = 1'b1;
        tick();
        redirect_valid = 1'b0; stall = 1'b0;
        check("redir bubble", {31'd0, instr_valid}, 32'd0);
        check("redir mem_address", {22'd0, mem_address}, 32'd5);
        tick(); check_instr("redir 5", 10'd5);
        tick(); check_instr("redir 6", 10'd6);

        // Arbitrary entry near the top of memory; stall during the bubble is ignored.
        start = 1'b1; prog_sel = 2'd3; start_addr = 10'd1022; stall = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check("wrap mem_address", {22'd0, mem_address}, 32'd1022);
        check("wrap bubble", {31'd0, instr_valid}, 32'd0);
        tick();
        stall = 1'b0;
        check_instr("wrap 1022", 10'd1022);
        tick(); check_instr("wrap 1023", 10'd1023);
        tick(); check_instr("wrap 0", 10'd0);
        tick(); check_instr("wrap 1", 10'd1);

        // Halt beats redirect; HALT ignores everything but start.
        redirect_valid = 1'b1; redirect_addr = 10'd100; halt_req = 1'b1;
        tick();
        redirect_valid = 1'b0; halt_req = 1'b0;
        check("halt valid", {31'd0, instr_valid}, 32'd0);
        check("halt busy", {31'd0, busy}, 32'd0);
        check("halt mem_address", {22'd0, mem_address}, 32'd2);
        redirect_valid = 1'b1; stall = 1'b1;
        tick();
        redirect_valid = 1'b0; stall = 1'b0;
        check("halt hold mem_address", {22'd0, mem_address}, 32'd2);
        check("halt hold busy", {31'd0, busy}, 32'd0);

        start = 1'b1; prog_sel = 2'd2;
        tick();
        start = 1'b0;
        check("p3 mem_address", {22'd0, mem_address}, 32'd22);
        check("p3 busy", {31'd0, busy}, 32'd1);
        tick(); check_instr("p3 22", 10'd22);
        tick(); check_instr("p3 23", 10'd23);

        // Start beats halt in the same cycle.
        start = 1'b1; halt_req = 1'b1; prog_sel = 2'd0;
        tick();
        start = 1'b0; halt_req = 1'b0;
        check("start>halt busy", {31'd0, busy}, 32'd1);
        check("start>halt mem_address", {22'd0, mem_address}, 32'd0);
        tick(); check_instr("start>halt 0", 10'd0);
        tick(); check_instr("start>halt 1", 10'd1);

        // Asynchronous reset in mid-cycle.
        #2 reset = 1'b1;
        #1;
        check("async valid", {31'd0, instr_valid}, 32'd0);
        check("async busy", {31'd0, busy}, 32'd0);
        check("async mem_address", {22'd0, mem_address}, 32'd0);
        check("async instr_out", instr_out, 32'd0);
        check("async instr_pc", {22'd0, instr_pc}, 32'd0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post reset valid", {31'd0, instr_valid}, 32'd0);
            check("post reset busy", {31'd0, busy}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
